// File: rtl/ingreso_operandos.sv
// Operand-entry controller: synchronizes the board inputs, debounces ENTER and
// steps A -> B -> operator -> result, producing the display selector and operands.
module ingreso_operandos #(
  parameter int in_length       = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 BTN_ENTER,
  input  logic                 BTN_CLEAR,
  input  logic [in_length-1:0] SWITCHES,
  input  logic [1:0]           OP_SEL,
  output logic [1:0]           STATE,
  output logic [in_length-1:0] A_OUT,
  output logic [in_length-1:0] B_OUT,
  output logic [1:0]           OP_OUT,
  output logic                 RESULT_VALID
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_NO_DATA = 2'd0,
    S_SHOW_A  = 2'd1,
    S_SHOW_B  = 2'd2,
    S_RESULT  = 2'd3
  } state_t;

  logic                 r_enter_meta, r_enter_sync;
  logic                 r_clear_meta, r_clear_sync;
  logic [in_length-1:0] r_sw_meta, r_sw_sync;
  logic [1:0]           r_op_meta, r_op_sync;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_enter_stable, r_enter_stable_d;
  logic                 w_enter_pulse;
  state_t               r_state;
  logic [in_length-1:0] r_a, r_b;
  logic [1:0]           r_op;
  logic                 r_valid;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_enter_meta <= 1'b0;
      r_enter_sync <= 1'b0;
      r_clear_meta <= 1'b0;
      r_clear_sync <= 1'b0;
      r_sw_meta    <= '0;
      r_sw_sync    <= '0;
      r_op_meta    <= '0;
      r_op_sync    <= '0;
    end else begin
      r_enter_meta <= BTN_ENTER;
      r_enter_sync <= r_enter_meta;
      r_clear_meta <= BTN_CLEAR;
      r_clear_sync <= r_clear_meta;
      r_sw_meta    <= SWITCHES;
      r_sw_sync    <= r_sw_meta;
      r_op_meta    <= OP_SEL;
      r_op_sync    <= r_op_meta;
    end
  end

  // Any cycle where the synchronized level agrees with the accepted one restarts the count.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt            <= '0;
      r_enter_stable   <= 1'b0;
      r_enter_stable_d <= 1'b0;
    end else begin
      r_enter_stable_d <= r_enter_stable;
      if (r_enter_sync == r_enter_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt          <= '0;
        r_enter_stable <= r_enter_sync;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_enter_pulse = r_enter_stable & ~r_enter_stable_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_NO_DATA;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
    end else if (r_clear_sync) begin
      r_state <= S_NO_DATA;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
    end else if (w_enter_pulse) begin
      case (r_state)
        S_NO_DATA: begin
          r_state <= S_SHOW_A;
          r_a     <= r_sw_sync;
        end
        S_SHOW_A: begin
          r_state <= S_SHOW_B;
          r_b     <= r_sw_sync;
        end
        S_SHOW_B: begin
          r_state <= S_RESULT;
          r_op    <= r_op_sync;
          r_valid <= 1'b1;
        end
        default: begin
          r_state <= S_NO_DATA;
          r_a     <= '0;
          r_b     <= '0;
          r_op    <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign STATE        = r_state;
  assign A_OUT        = r_a;
  assign B_OUT        = r_b;
  assign OP_OUT       = r_op;
  assign RESULT_VALID = r_valid;

endmodule

// File: tb/tb_ingreso_operandos.sv
// Directed bench for ingreso_operandos with a short debounce window (4 cycles).
module tb_ingreso_operandos;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic         btn_enter;
  logic         btn_clear;
  logic [W-1:0] switches;
  logic [1:0]   op_sel;
  logic [1:0]   state;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic [1:0]   op_out;
  logic         result_valid;

  int n_checks = 0;
  int n_fail   = 0;

  ingreso_operandos #(.in_length(W), .DEBOUNCE_CYCLES(D)) dut (
    .CLK(clk),
    .RESET(rst_n),
    .BTN_ENTER(btn_enter),
    .BTN_CLEAR(btn_clear),
    .SWITCHES(switches),
    .OP_SEL(op_sel),
    .STATE(state),
    .A_OUT(a_out),
    .B_OUT(b_out),
    .OP_OUT(op_out),
    .RESULT_VALID(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sw;
    logic [1:0]   op;
    logic [1:0]   prev_state;
    logic [1:0]   exp_state;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    logic [1:0]   exp_op;
    logic         exp_valid;
  } vec_t;

  vec_t vecs[4];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] o, input logic v);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".a"}, 32'(a_out), 32'(a));
    chk({tag, ".b"}, 32'(b_out), 32'(b));
    chk({tag, ".op"}, 32'(op_out), 32'(o));
    chk({tag, ".valid"}, 32'(result_valid), 32'(v));
  endtask

  // Press from a negedge: edge k is the next posedge; nothing may change through k+5, update at k+6.
  task automatic press_hold(input string tag, input logic [1:0] prev, input logic [1:0] s,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] o, input logic v);
    btn_enter = 1'b1;
    tick(D + 2);
    chk({tag, ".early"}, 32'(state), 32'(prev));
    tick(1);
    chk_all(tag, s, a, b, o, v);
    $display("press %s: state=%0d a=%h b=%h op=%0d valid=%0b", tag, state, a_out, b_out, op_out, result_valid);
  endtask

  task automatic release_btn();
    btn_enter = 1'b0;
    tick(D + 6);
  endtask

  initial begin
    vecs[0] = '{sw: 16'h0012, op: 2'd0, prev_state: 2'd0, exp_state: 2'd1,
                exp_a: 16'h0012, exp_b: 16'h0000, exp_op: 2'd0, exp_valid: 1'b0};
    vecs[1] = '{sw: 16'h0034, op: 2'd0, prev_state: 2'd1, exp_state: 2'd2,
                exp_a: 16'h0012, exp_b: 16'h0034, exp_op: 2'd0, exp_valid: 1'b0};
    vecs[2] = '{sw: 16'h0055, op: 2'b10, prev_state: 2'd2, exp_state: 2'd3,
                exp_a: 16'h0012, exp_b: 16'h0034, exp_op: 2'b10, exp_valid: 1'b1};
    vecs[3] = '{sw: 16'h0077, op: 2'b01, prev_state: 2'd3, exp_state: 2'd0,
                exp_a: 16'h0000, exp_b: 16'h0000, exp_op: 2'd0, exp_valid: 1'b0};

    rst_n     = 1'b0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    switches  = '0;
    op_sel    = '0;

    // Reset state, both while held and after release.
    tick(3);
    chk_all("reset_held", 2'd0, '0, '0, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick(3);
    chk_all("reset_rel", 2'd0, '0, '0, 2'd0, 1'b0);
    $display("reset: state=%0d a=%h b=%h op=%0d valid=%0b", state, a_out, b_out, op_out, result_valid);

    // Full entry sequence; switch values change after each capture.
    for (int i = 0; i < 4; i++) begin
      switches = vecs[i].sw;
      op_sel   = vecs[i].op;
      press_hold($sformatf("seq%0d", i), vecs[i].prev_state, vecs[i].exp_state,
                 vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_op, vecs[i].exp_valid);
      if (i == 0) begin
        switches = 16'hBEEF;
        tick(50);
        chk_all("hold50", 2'd1, 16'h0012, '0, 2'd0, 1'b0);
        $display("hold50: state=%0d a=%h", state, a_out);
      end
      release_btn();
    end

    // Bounce: 2-cycle pulses never reach the 4-cycle window.
    switches = 16'h00AB;
    for (int i = 0; i < 10; i++) begin
      btn_enter = (i % 2 == 0);
      tick(2);
    end
    btn_enter = 1'b0;
    tick(10);
    chk_all("bounce", 2'd0, '0, '0, 2'd0, 1'b0);
    $display("bounce: state=%0d", state);
    press_hold("bounce_hold", 2'd0, 2'd1, 16'h00AB, '0, 2'd0, 1'b0);
    release_btn();

    // Clear arrives on the same edge as the S2->S3 pulse and wins.
    switches = 16'h00CD;
    press_hold("to_s2", 2'd1, 2'd2, 16'h00AB, 16'h00CD, 2'd0, 1'b0);
    release_btn();
    op_sel    = 2'b11;
    btn_enter = 1'b1;
    tick(4);
    btn_clear = 1'b1;
    tick(1);
    btn_clear = 1'b0;
    tick(1);
    chk("clr_pre.state", 32'(state), 32'd2);
    tick(1);
    chk_all("clr_collide", 2'd0, '0, '0, 2'd0, 1'b0);
    $display("clear+enter: state=%0d op=%0d", state, op_out);
    tick(20);
    chk("clr_held.state", 32'(state), 32'd0);
    release_btn();

    // Asynchronous reset in the middle of a debounce count.
    switches = 16'h0099;
    press_hold("to_s1", 2'd0, 2'd1, 16'h0099, '0, 2'd0, 1'b0);
    release_btn();
    switches  = 16'h0066;
    btn_enter = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, '0, '0, 2'd0, 1'b0);
    $display("async reset: state=%0d a=%h", state, a_out);
    tick(1);
    rst_n = 1'b1;
    tick(D + 2);
    chk("rst_relat.early", 32'(state), 32'd0);
    tick(1);
    chk_all("rst_relat", 2'd1, 16'h0066, '0, 2'd0, 1'b0);
    $display("post-reset press: state=%0d a=%h", state, a_out);
    release_btn();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
